// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types for the round-robin FIFO read arbiter.
// Holds the FSM state encoding and the burst counter width.
package fifo_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        OUT
    } state_t;

    localparam int BCW = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request at or after 'start', wrapping past N-1.
module rr_pick
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic [IDW-1:0] grant,
    output logic           any
);

    int idx;

    // Scan from the farthest offset down, so the nearest hit is written last and wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (req[idx]) begin
                grant = IDW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read arbiter draining N FIFOs into one valid/ready stream.
// Each output word carries the index of the FIFO it came from.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    parameter  int BURST = 1,
    localparam int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sclr,
    input  logic [N-1:0]       fifo_empty,
    output logic [N-1:0]       fifo_rdreq,
    input  logic [N*WIDTH-1:0] fifo_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDW-1:0]     out_id,
    output logic               busy
);

    localparam logic [IDW-1:0] LAST_INIT = IDW'(N - 1);
    localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST - 1);

    state_t           state_reg, state_next;
    logic [IDW-1:0]   grant_reg, grant_next;
    logic [IDW-1:0]   last_reg, last_next;
    logic [BCW-1:0]   burst_cnt_reg, burst_cnt_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [IDW-1:0]   out_id_reg, out_id_next;

    logic [WIDTH-1:0] q_slice [N];
    logic [IDW-1:0]   pick_base;
    logic [IDW-1:0]   pick_start;
    logic [IDW-1:0]   pick_grant;
    logic             pick_any;

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign q_slice[gi] = fifo_q[gi*WIDTH +: WIDTH];
    end

    // One picker serves both IDLE (search after last) and OUT (search after grant).
    assign pick_base  = (state_reg == OUT) ? grant_reg : last_reg;
    assign pick_start = (pick_base == LAST_INIT) ? '0 : IDW'(pick_base + 1'b1);

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (~fifo_empty),
        .start (pick_start),
        .grant (pick_grant),
        .any   (pick_any)
    );

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        last_next      = last_reg;
        burst_cnt_next = burst_cnt_reg;
        out_data_next  = out_data_reg;
        out_id_next    = out_id_reg;
        fifo_rdreq     = '0;
        unique case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    grant_next     = pick_grant;
                    burst_cnt_next = '0;
                    state_next     = RD;
                end
            end
            RD: begin
                // An empty FIFO here means the source misbehaved; abandon without output.
                if (fifo_empty[grant_reg]) begin
                    state_next = IDLE;
                end else begin
                    fifo_rdreq[grant_reg] = 1'b1;
                    state_next            = CAP;
                end
            end
            CAP: begin
                out_data_next = q_slice[grant_reg];
                out_id_next   = grant_reg;
                last_next     = grant_reg;
                state_next    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (burst_cnt_reg < BURST_MAX && !fifo_empty[grant_reg]) begin
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                        state_next     = RD;
                    end else if (pick_any) begin
                        grant_next     = pick_grant;
                        burst_cnt_next = '0;
                        state_next     = RD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || sclr) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            last_reg      <= LAST_INIT;
            burst_cnt_reg <= '0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            last_reg      <= last_next;
            burst_cnt_reg <= burst_cnt_next;
            out_data_reg  <= out_data_next;
            out_id_reg    <= out_id_next;
        end
    end

    assign out_valid = (state_reg == OUT);
    assign busy      = (state_reg != IDLE);
    assign out_data  = out_data_reg;
    assign out_id    = out_id_reg;

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

- Round-robin read arbiter that drains N `simple_fifo` instances into one output stream with a valid/ready handshake.
- Sits downstream of the per-requester FIFOs. It watches their `empty` flags, drives their `rdreq`, and captures `q`.
- Each word is tagged with its source index.
- An optional per-grant burst limit lets one FIFO send up to BURST words before the grant rotates.

## Interface
- N, 4: number of source FIFOs (2..16).
- WIDTH, 8: data width; must match the FIFO `width`.
- BURST, 1: maximum words per grant before rotating (1..255).
- IDW, $clog2(N): derived width of the source index; not for override.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- sclr  in  1  synchronous clear, same effect as reset; takes priority over all other inputs.
- fifo_empty  in  N  empty flag of each source FIFO.
- fifo_rdreq  out  N  one-hot read request to the source FIFOs.
- fifo_q  in  N*WIDTH  concatenated FIFO outputs; slice i is bits [i*WIDTH +: WIDTH].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WIDTH  captured word.
- out_id  out  IDW  index of the source FIFO for out_data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, RD, CAP, OUT; reset or sclr forces IDLE.
- IDLE:
  - rr_pick chooses the first non-empty FIFO, searching from index (last+1) mod N upward with wrap.
  - If one is found: register it as grant, clear burst_cnt to 0, go to RD. Otherwise stay in IDLE.
- RD:
  - fifo_rdreq[grant] = ~fifo_empty[grant]; all other bits are 0.
  - If fifo_empty[grant] is high (a protocol violation), go to IDLE with no output. Otherwise go to CAP.
- CAP: out_data <= fifo_q slice [grant], out_id <= grant, last <= grant; go to OUT.
- OUT:
  - out_valid = 1. out_data and out_id stay stable until out_ready.
  - While out_ready is low, remain in OUT.
- On the OUT handshake (out_valid & out_ready):
  - If burst_cnt < BURST-1 and fifo_empty[grant] is low: increment burst_cnt and go to RD with the same grant.
  - Else, if rr_pick finds any non-empty FIFO searching from grant+1: load the new grant, clear burst_cnt, go to RD.
  - Else go to IDLE.
- fifo_rdreq is never asserted outside RD, never has more than one bit set, and never goes to an empty FIFO.
- The `last` pointer resets to N-1, so index 0 wins the first arbitration.
- burst_cnt is 8 bits wide and compared unsigned; it never wraps because BURST ≤ 255.

## Timing
- Reset and sclr values:
  - fifo_rdreq = 0, out_valid = 0, out_data = 0, out_id = 0, busy = 0.
  - last = N-1, burst_cnt = 0, state = IDLE.
- FIFO read latency is one cycle: q is valid in the cycle after rdreq.
- Latency: fifo_empty falls before edge k; fifo_rdreq is high in cycle k+1; out_valid rises in cycle k+3.
- Throughput with out_ready held high: one word every 3 cycles, on the OUT→RD→CAP→OUT cycle.
- Back-to-back handshakes: the OUT-cycle decision uses the current fifo_empty, which already reflects the read issued two cycles earlier.
- Reset or sclr mid-read (in RD or CAP): the word already popped from the FIFO is discarded. The system clears the FIFOs with the same sclr.
- Reset or sclr in OUT: the pending word is dropped and out_valid falls at the next edge.
- Simultaneous requests: exactly one grant, by round-robin. Starvation is bounded at (N-1)*BURST words.

## Structure
- Package fifo_rr_arbiter_pkg holds:
  - the state enum (IDLE, RD, CAP, OUT);
  - the localparam BCW = 8.
- Sub-module rr_pick is purely combinational.
  - Inputs: req[N], start index.
  - Outputs: grant index, any.
  - It is instantiated once and shared by IDLE and OUT.
- All state lives in fifo_rr_arbiter.

## Test plan
- Single source: N=4, BURST=1, FIFO 2 preloaded with 0x11 and 0x22, out_ready=1. Required: rdreq = 4'b0100 twice; outputs (0x11, id 2) then (0x22, id 2), 3 cycles apart; then IDLE with busy=0.
- Round-robin: all four FIFOs hold one word each (0xA0+i), BURST=1. Required: out_id order 0,1,2,3. Refill FIFO 0 and FIFO 3 after last=3; required: next order 0,3.
- Burst: BURST=3, FIFOs 0 and 1 each hold 4 words. Required: out_id sequence 0,0,0,1,1,1,0,1.
- Backpressure: hold out_ready=0 for 5 cycles in OUT. Required: out_valid stays 1 with out_data and out_id unchanged, and no rdreq is issued. The word transfers on the cycle out_ready rises.
- Clear mid-operation: assert sclr for one cycle during CAP. Required: next cycle state is IDLE, out_valid=0, last=N-1, and the next grant goes to the lowest non-empty index.
- Protocol check: force fifo_empty[grant]=1 during RD. Required: rdreq stays 0, no out_valid, and the FSM returns to IDLE.
